// File: rtl/snake_dir_if.sv
// Bus between the snake direction controller and its surroundings:
// raw buttons and game_over in, conditioned direction and tick out.
interface snake_dir_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       game_over;
   logic [4:0] dir;
   logic       move_tick;
   logic [1:0] turn_pending;
   logic [3:0] btn_level;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, game_over,
      input  dir, move_tick, turn_pending, btn_level
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, game_over,
      output dir, move_tick, turn_pending, btn_level
   );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake input conditioning: button sync/debounce, turn legality filter,
// two-deep turn queue and periodic move_tick generation.
module snake_dir_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_CYCLES     = 2097152
) (
   input  logic       board_clk,
   input  logic       reset,
   snake_dir_if.slave bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DEB_ONE   = DW'(1'b1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1'b1);
   localparam logic [4:0] DIR_INI   = 5'b00001;
   localparam logic [4:0] DIR_UP    = 5'b00010;
   localparam logic [4:0] DIR_DOWN  = 5'b00100;
   localparam logic [4:0] DIR_LEFT  = 5'b01000;
   localparam logic [4:0] DIR_RIGHT = 5'b10000;

   typedef enum logic [0:0] {ST_INI = 1'b0, ST_RUN = 1'b1} state_t;

   function automatic logic [4:0] opposite_dir(input logic [4:0] d);
      case (d)
         DIR_UP:    return DIR_DOWN;
         DIR_DOWN:  return DIR_UP;
         DIR_LEFT:  return DIR_RIGHT;
         DIR_RIGHT: return DIR_LEFT;
         default:   return DIR_INI;
      endcase
   endfunction

   logic [3:0]         raw_s, sync1_r, sync2_r, level_r, level_d_r, rise_s;
   logic [3:0][DW-1:0] deb_cnt_r;
   state_t             state_r, state_nx_s;
   logic [4:0]         dir_r, dir_nx_s, q0_r, q0_nx_s, q1_r, q1_nx_s;
   logic [4:0]         press_dir_s, ref_dir_s;
   logic               press_valid_s, legal_s;
   logic [TW-1:0]      tick_r, tick_nx_s;
   logic               move_tick_r, move_tick_nx_s;
   logic [1:0]         pending_r, pending_nx_s, fill_s;
   logic               wrap_s, deq_s, enq_s;

   assign raw_s  = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
   assign rise_s = level_r & ~level_d_r;

   // Two-flop synchronisers and per-button debounce counters
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         sync1_r   <= 4'b0000;
         sync2_r   <= 4'b0000;
         level_r   <= 4'b0000;
         level_d_r <= 4'b0000;
         deb_cnt_r <= {(4 * DW){1'b0}};
      end else begin
         sync1_r   <= raw_s;
         sync2_r   <= sync1_r;
         level_d_r <= level_r;
         for (int i = 0; i < 4; i++) begin
            if (sync2_r[i] != level_r[i]) begin
               if (deb_cnt_r[i] == DEB_LAST) begin
                  level_r[i]   <= ~level_r[i];
                  deb_cnt_r[i] <= {DW{1'b0}};
               end else begin
                  deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
               end
            end else begin
               deb_cnt_r[i] <= {DW{1'b0}};
            end
         end
      end
   end

   // Press priority UP > DOWN > LEFT > RIGHT and legality against the reference direction
   always_comb begin
      press_valid_s = 1'b1;
      if (rise_s[0]) begin
         press_dir_s = DIR_UP;
      end else if (rise_s[1]) begin
         press_dir_s = DIR_DOWN;
      end else if (rise_s[2]) begin
         press_dir_s = DIR_LEFT;
      end else if (rise_s[3]) begin
         press_dir_s = DIR_RIGHT;
      end else begin
         press_dir_s   = DIR_INI;
         press_valid_s = 1'b0;
      end
      case (pending_r)
         2'd1:    ref_dir_s = q0_r;
         2'd2:    ref_dir_s = q1_r;
         default: ref_dir_s = dir_r;
      endcase
      legal_s = press_valid_s && (press_dir_s != ref_dir_s)
                && (press_dir_s != opposite_dir(ref_dir_s));
   end

   // FSM state register
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_INI;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next state: game_over always wins
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_INI: begin
            if (bus.game_over) begin
               state_nx_s = ST_INI;
            end else if (press_valid_s) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_INI;
            end
         end
         ST_RUN: begin
            if (bus.game_over) begin
               state_nx_s = ST_INI;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         default: state_nx_s = ST_INI;
      endcase
   end

   // FSM outputs: next direction, queue contents and tick timer
   always_comb begin
      dir_nx_s       = dir_r;
      tick_nx_s      = tick_r;
      move_tick_nx_s = 1'b0;
      q0_nx_s        = q0_r;
      q1_nx_s        = q1_r;
      pending_nx_s   = pending_r;
      wrap_s         = 1'b0;
      deq_s          = 1'b0;
      enq_s          = 1'b0;
      fill_s         = pending_r;
      case (state_r)
         ST_INI: begin
            tick_nx_s    = {TW{1'b0}};
            pending_nx_s = 2'd0;
            if (bus.game_over) begin
               dir_nx_s = DIR_INI;
            end else if (press_valid_s) begin
               dir_nx_s = press_dir_s;
            end else begin
               dir_nx_s = DIR_INI;
            end
         end
         ST_RUN: begin
            if (bus.game_over) begin
               dir_nx_s     = DIR_INI;
               tick_nx_s    = {TW{1'b0}};
               pending_nx_s = 2'd0;
               q0_nx_s      = DIR_INI;
               q1_nx_s      = DIR_INI;
            end else begin
               wrap_s         = (tick_r == TICK_LAST);
               tick_nx_s      = wrap_s ? {TW{1'b0}} : tick_r + TICK_ONE;
               move_tick_nx_s = wrap_s;
               deq_s          = wrap_s && (pending_r != 2'd0);
               if (deq_s) begin
                  dir_nx_s = q0_r;
                  q0_nx_s  = q1_r;
               end else begin
                  dir_nx_s = dir_r;
               end
               // a dequeue on this edge frees a slot for a same-cycle press
               fill_s = pending_r - {1'b0, deq_s};
               enq_s  = legal_s && ((pending_r != 2'd2) || deq_s);
               if (enq_s) begin
                  if (fill_s == 2'd0) begin
                     q0_nx_s = press_dir_s;
                  end else begin
                     q1_nx_s = press_dir_s;
                  end
                  pending_nx_s = fill_s + 2'd1;
               end else begin
                  pending_nx_s = fill_s;
               end
            end
         end
         default: begin
            dir_nx_s     = DIR_INI;
            tick_nx_s    = {TW{1'b0}};
            pending_nx_s = 2'd0;
            q0_nx_s      = DIR_INI;
            q1_nx_s      = DIR_INI;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         dir_r       <= DIR_INI;
         tick_r      <= {TW{1'b0}};
         move_tick_r <= 1'b0;
         q0_r        <= DIR_INI;
         q1_r        <= DIR_INI;
         pending_r   <= 2'd0;
      end else begin
         dir_r       <= dir_nx_s;
         tick_r      <= tick_nx_s;
         move_tick_r <= move_tick_nx_s;
         q0_r        <= q0_nx_s;
         q1_r        <= q1_nx_s;
         pending_r   <= pending_nx_s;
      end
   end

   assign bus.dir          = dir_r;
   assign bus.move_tick    = move_tick_r;
   assign bus.turn_pending = pending_r;
   assign bus.btn_level    = level_r;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random buttons against
// a cycle-level reference model built from queues and cycle counts.
module tb_snake_dir_ctrl;
   localparam int DEB  = 4;
   localparam int TICK = 8;

   logic board_clk = 1'b0;
   logic reset;
   snake_dir_if bus ();

   snake_dir_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
      .board_clk(board_clk),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 board_clk = ~board_clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [11:0] dut_vec;
   assign dut_vec = {bus.dir, bus.move_tick, bus.turn_pending, bus.btn_level};

   // Reference model: directions coded 0=INI 1=UP 2=DOWN 3=LEFT 4=RIGHT
   logic [3:0] m_sync1, m_sync2, m_level, m_level_old;
   int         m_run[4];
   bit         m_running;
   int         m_dir;
   int         m_q[$];
   int         m_age;
   bit         m_tick;

   function automatic logic [11:0] model_vec();
      logic [4:0] d;
      d = 5'(1 << m_dir);
      return {d, m_tick, 2'(m_q.size()), m_level};
   endfunction

   task automatic model_init();
      m_sync1 = 4'b0; m_sync2 = 4'b0; m_level = 4'b0; m_level_old = 4'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_running = 1'b0; m_dir = 0; m_q.delete(); m_age = 0; m_tick = 1'b0;
   endtask

   task automatic model_update();
      int press, refd;
      bit tick_nx;
      press = 0;
      for (int i = 3; i >= 0; i--) if (m_level[i] && !m_level_old[i]) press = i + 1;
      tick_nx = 1'b0;
      if (bus.game_over) begin
         m_running = 1'b0; m_dir = 0; m_q.delete(); m_age = 0;
      end else if (!m_running) begin
         if (press != 0) begin m_running = 1'b1; m_dir = press; m_age = 0; end
      end else begin
         refd = (m_q.size() > 0) ? m_q[$] : m_dir;
         m_age++;
         tick_nx = (m_age % TICK == 0);
         if (tick_nx && m_q.size() > 0) m_dir = m_q.pop_front();
         if (press != 0 && press != refd && press + refd != 3 && press + refd != 7
             && m_q.size() < 2) m_q.push_back(press);
      end
      m_tick = tick_nx;
      m_level_old = m_level;
      for (int i = 0; i < 4; i++) begin
         if (m_sync2[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin m_level[i] = ~m_level[i]; m_run[i] = 0; end
         end else begin
            m_run[i] = 0;
         end
      end
      m_sync2 = m_sync1;
      m_sync1 = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
   endtask

   task automatic step();
      if (reset) model_init(); else model_update();
      @(posedge board_clk);
      #1;
   endtask

   task automatic set_btns(input logic [3:0] b);
      {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = b;
   endtask

   task automatic test_reset();
      reset = 1'b1; set_btns(4'b0); bus.game_over = 1'b0; model_init();
      #2;
      n_cmp++;
      if (dut_vec !== 12'b00001_0_00_0000) begin
         n_err++; $display("FAIL reset_values got=%h want=%h", dut_vec, 12'b00001_0_00_0000);
      end
      step(); step();
      reset = 1'b0;
      for (int k = 0; k < 100; k++) begin
         step();
         n_cmp++;
         if (bus.dir !== 5'b00001 || bus.move_tick !== 1'b0 || bus.turn_pending !== 2'd0) begin
            n_err++; $display("FAIL idle_after_reset got=%h want=%h", dut_vec, 12'b00001_0_00_0000);
         end
      end
   endtask

   task automatic test_debounce();
      bus.btn_up = 1'b1;
      repeat (3) step();
      bus.btn_up = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         n_cmp++;
         if (bus.btn_level !== 4'b0000 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL glitch_level got=%h want=%h", dut_vec, model_vec());
         end
      end
      bus.btn_up = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         n_cmp++;
         if (bus.btn_level[0] !== (k == 6)) begin
            n_err++; $display("FAIL debounce_latency cycle=%0d got=%b want=%b", k, bus.btn_level[0], (k == 6));
         end
      end
      step();
      n_cmp++;
      if (bus.dir !== 5'b00010) begin
         n_err++; $display("FAIL first_dir got=%b want=%b", bus.dir, 5'b00010);
      end
      for (int k = 1; k <= 40; k++) begin
         if (k == 4) bus.btn_up = 1'b0;
         step();
         n_cmp++;
         if (bus.move_tick !== ((k % TICK) == 0) || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL tick_period k=%0d got=%h want=%h", k, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_illegal_turn();
      bit seen_pend;
      bit done;
      bus.btn_down = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k == 8) bus.btn_down = 1'b0;
         step();
         n_cmp++;
         if (bus.turn_pending !== 2'd0 || bus.dir !== 5'b00010 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL reverse_dropped got=%h want=%h", dut_vec, model_vec());
         end
      end
      seen_pend = 1'b0; done = 1'b0;
      bus.btn_left = 1'b1;
      for (int k = 0; k < 24 && !done; k++) begin
         if (k == 8) bus.btn_left = 1'b0;
         step();
         if (bus.turn_pending === 2'd1) seen_pend = 1'b1;
         if (bus.move_tick === 1'b1 && seen_pend) begin
            done = 1'b1;
            n_cmp++;
            if (bus.dir !== 5'b01000 || bus.turn_pending !== 2'd0) begin
               n_err++; $display("FAIL left_applied got=%h want=%h", {bus.dir, bus.turn_pending}, {5'b01000, 2'd0});
            end
         end
      end
      bus.btn_left = 1'b0;
      n_cmp++;
      if (!done) begin
         n_err++; $display("FAIL left_timeout got=%b want=%b", done, 1'b1);
      end
      repeat (10) step();
   endtask

   task automatic wait_tick(input string what);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 16 && !found; k++) begin
         step();
         if (bus.move_tick === 1'b1) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_err++; $display("FAIL %s_tick_timeout got=%b want=%b", what, found, 1'b1);
      end
   endtask

   task automatic test_queue_two();
      bit found;
      bus.game_over = 1'b1; step(); bus.game_over = 1'b0;
      n_cmp++;
      if (bus.dir !== 5'b00001) begin
         n_err++; $display("FAIL game_over_ini got=%b want=%b", bus.dir, 5'b00001);
      end
      found = 1'b0;
      bus.btn_right = 1'b1;
      for (int k = 0; k < 12 && !found; k++) begin
         step();
         if (bus.dir !== 5'b00001) found = 1'b1;
      end
      bus.btn_right = 1'b0;
      n_cmp++;
      if (bus.dir !== 5'b10000) begin
         n_err++; $display("FAIL start_right got=%b want=%b", bus.dir, 5'b10000);
      end
      wait_tick("queue");
      step(); bus.btn_up = 1'b1;
      step(); bus.btn_left = 1'b1;
      step(); bus.btn_down = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         if (k == 8) set_btns(4'b0);
         step();
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_err++; $display("FAIL queue_model k=%0d got=%h want=%h", k, dut_vec, model_vec());
         end
         if (k == 7) begin
            n_cmp++;
            if (bus.turn_pending !== 2'd2 || bus.dir !== 5'b10000) begin
               n_err++; $display("FAIL queue_full got=%h want=%h", {bus.dir, bus.turn_pending}, {5'b10000, 2'd2});
            end
         end
         if (k == 13) begin
            n_cmp++;
            if (bus.move_tick !== 1'b1 || bus.dir !== 5'b00010 || bus.turn_pending !== 2'd1) begin
               n_err++; $display("FAIL tick_n_up got=%h want=%h", dut_vec[11:4], {5'b00010, 1'b1, 2'd1});
            end
         end
         if (k == 21) begin
            n_cmp++;
            if (bus.move_tick !== 1'b1 || bus.dir !== 5'b01000 || bus.turn_pending !== 2'd0) begin
               n_err++; $display("FAIL tick_n1_left got=%h want=%h", dut_vec[11:4], {5'b01000, 1'b1, 2'd0});
            end
         end
      end
   endtask

   task automatic test_same_cycle();
      bit found;
      bus.game_over = 1'b1; step(); bus.game_over = 1'b0;
      repeat (10) step();
      found = 1'b0;
      bus.btn_up = 1'b1; bus.btn_left = 1'b1;
      for (int k = 0; k < 12 && !found; k++) begin
         step();
         if (bus.dir !== 5'b00001) found = 1'b1;
      end
      n_cmp++;
      if (bus.dir !== 5'b00010 || bus.turn_pending !== 2'd0) begin
         n_err++; $display("FAIL same_cycle_prio got=%h want=%h", {bus.dir, bus.turn_pending}, {5'b00010, 2'd0});
      end
      repeat (3) step();
      n_cmp++;
      if (bus.turn_pending !== 2'd0 || dut_vec !== model_vec()) begin
         n_err++; $display("FAIL same_cycle_drop got=%h want=%h", dut_vec, model_vec());
      end
      set_btns(4'b0);
      repeat (10) step();
   endtask

   task automatic test_game_over();
      wait_tick("game_over");
      step(); bus.btn_left = 1'b1;
      step(); bus.btn_down = 1'b1;
      repeat (7) step();
      n_cmp++;
      if (bus.turn_pending !== 2'd2) begin
         n_err++; $display("FAIL pending_two got=%0d want=%0d", bus.turn_pending, 2);
      end
      set_btns(4'b0);
      bus.game_over = 1'b1; step(); bus.game_over = 1'b0;
      n_cmp++;
      if (bus.dir !== 5'b00001 || bus.turn_pending !== 2'd0 || bus.move_tick !== 1'b0) begin
         n_err++; $display("FAIL game_over_flush got=%h want=%h", dut_vec[11:4], {5'b00001, 1'b0, 2'd0});
      end
      for (int k = 0; k < 50; k++) begin
         step();
         n_cmp++;
         if (bus.move_tick !== 1'b0 || bus.dir !== 5'b00001) begin
            n_err++; $display("FAIL no_tick_after_over got=%h want=%h", dut_vec[11:4], {5'b00001, 1'b0, 2'd0});
         end
      end
      bus.btn_right = 1'b1;
      repeat (3) step();
      reset = 1'b1;
      #1;
      model_init();
      n_cmp++;
      if (dut_vec !== 12'b00001_0_00_0000) begin
         n_err++; $display("FAIL mid_debounce_reset got=%h want=%h", dut_vec, 12'b00001_0_00_0000);
      end
      bus.btn_right = 1'b0;
      step(); step();
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         n_cmp++;
         if (bus.dir !== 5'b00001 || bus.btn_level !== 4'b0000 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL press_discarded got=%h want=%h", dut_vec, 12'b00001_0_00_0000);
         end
      end
   endtask

   task automatic test_random();
      int hold[4];
      logic [3:0] b;
      b = 4'b0;
      for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 14);
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            hold[i]--;
            if (hold[i] == 0) begin
               b[i] = ~b[i];
               hold[i] = $urandom_range(1, 14);
            end
         end
         set_btns(b);
         bus.game_over = ($urandom_range(0, 149) == 0);
         step();
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_err++; $display("FAIL random_model cycle=%0d got=%h want=%h", c, dut_vec, model_vec());
         end
      end
      set_btns(4'b0);
      bus.game_over = 1'b0;
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_illegal_turn();
      test_queue_two();
      test_same_cycle();
      test_game_over();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
